// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared types and constants for the LeNet run scheduler
package lenet_pkg;

    localparam int LENET_DIGIT_W   = 4;
    localparam int LENET_MAX_DIGIT = 9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_ACK = 3'd2,
        RUN      = 3'd3,
        CAPTURE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/lenet_scheduler_if.sv
// rtl/lenet_scheduler_if.sv - go/ready/digit handshake between scheduler and lenet engine
interface lenet_scheduler_if;
    import lenet_pkg::*;

    logic                     lenet_go;
    logic                     lenet_ready;
    logic [LENET_DIGIT_W-1:0] lenet_digit;

    modport master (output lenet_go, input lenet_ready, input lenet_digit);
    modport slave  (input lenet_go, output lenet_ready, output lenet_digit);
endinterface

// File: rtl/sync_pulse.sv
// rtl/sync_pulse.sv - multi-flop synchronizer with rising-edge detect on the synced level
module sync_pulse #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/lenet_scheduler.sv
// rtl/lenet_scheduler.sv - launches one lenet run per frame and filters digits; LENET_WDOG_EN adds a run watchdog
module lenet_scheduler
    import lenet_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 3,
    parameter int WDOG_CYCLES  = 1000000,
    parameter int RUN_CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_ready,
    input  logic                     enable,
    lenet_scheduler_if.master        eng,
    output logic                     frame_lock,
    output logic [LENET_DIGIT_W-1:0] digit_out,
    output logic                     digit_valid,
    output logic [RUN_CNT_W-1:0]     run_count,
    output logic                     overrun,
    output logic                     timeout_err
);
    localparam logic [2:0] ST_IDLE     = IDLE;
    localparam logic [2:0] ST_LAUNCH   = LAUNCH;
    localparam logic [2:0] ST_WAIT_ACK = WAIT_ACK;
    localparam logic [2:0] ST_RUN      = RUN;
    localparam logic [2:0] ST_CAPTURE  = CAPTURE;

    logic [2:0]               state, state_nx;
    logic                     rise, pending, wdog_hit;
    logic [LENET_DIGIT_W-1:0] cand, fcount, fcount_nx;

    sync_pulse #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (data_ready),
        .rise  (rise)
    );

`ifdef LENET_WDOG_EN
    logic [31:0] wdog_cnt;

    assign wdog_hit = ((state == ST_WAIT_ACK) || (state == ST_RUN)) &&
                      (wdog_cnt == 32'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_LAUNCH)
                wdog_cnt <= '0;
            else if ((state == ST_WAIT_ACK) || (state == ST_RUN))
                wdog_cnt <= wdog_cnt + 32'd1;
            if (wdog_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (pending && enable && eng.lenet_ready) state_nx = ST_LAUNCH;
            ST_LAUNCH:   state_nx = ST_WAIT_ACK;
            ST_WAIT_ACK: if (wdog_hit) state_nx = ST_IDLE;
                         else if (!eng.lenet_ready) state_nx = ST_RUN;
            ST_RUN:      if (wdog_hit) state_nx = ST_IDLE;
                         else if (eng.lenet_ready) state_nx = ST_CAPTURE;
            ST_CAPTURE:  state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // A repeat of the candidate saturates; any other valid digit restarts the streak at 1.
    always_comb begin
        fcount_nx = 4'd1;
        if (eng.lenet_digit == cand)
            fcount_nx = (fcount >= 4'(STABLE_COUNT)) ? 4'(STABLE_COUNT) : fcount + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            eng.lenet_go <= 1'b0;
            frame_lock   <= 1'b0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            run_count    <= '0;
            cand         <= '0;
            fcount       <= '0;
            digit_out    <= '0;
            digit_valid  <= 1'b0;
        end else begin
            state        <= state_nx;
            eng.lenet_go <= (state_nx == ST_LAUNCH);
            frame_lock   <= (state_nx != ST_IDLE);

            // An edge landing in LAUNCH refills the slot being consumed, so it is not an overrun.
            if (rise) begin
                pending <= 1'b1;
                if (pending && (state != ST_LAUNCH))
                    overrun <= 1'b1;
            end else if (state == ST_LAUNCH) begin
                pending <= 1'b0;
            end

            if (state == ST_CAPTURE) begin
                run_count <= run_count + 1'b1;
                if (eng.lenet_digit > 4'(LENET_MAX_DIGIT)) begin
                    fcount <= '0;
                end else begin
                    cand   <= eng.lenet_digit;
                    fcount <= fcount_nx;
                    if (fcount_nx == 4'(STABLE_COUNT)) begin
                        digit_out   <= eng.lenet_digit;
                        digit_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lenet_scheduler.sv
// tb/tb_lenet_scheduler.sv - directed self-checking bench for lenet_scheduler
module tb_lenet_scheduler;
    import lenet_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ready = 1'b0;
    logic        enable = 1'b0;
    logic        frame_lock, digit_valid, overrun, timeout_err;
    logic [3:0]  digit_out;
    logic [15:0] run_count;

    lenet_scheduler_if eng();

    lenet_scheduler #(
        .SYNC_STAGES  (2),
        .STABLE_COUNT (3),
        .WDOG_CYCLES  (50),
        .RUN_CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_ready  (data_ready),
        .enable      (enable),
        .eng         (eng),
        .frame_lock  (frame_lock),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .run_count   (run_count),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         eng_len = 100;
    logic [3:0] eng_digit = 4'd0;
    bit         eng_hang = 1'b0;
    bit         eng_busy = 1'b0;
    int         eng_cnt = 0;
    int         go_count = 0;
    int         fl_cnt = 0;
    int         go_base = 0;
    logic [15:0] rc_base;

    // Engine model: ready drops one cycle after go, rises eng_len cycles later with eng_digit.
    always @(negedge clk) begin
        if (!rst_n) begin
            eng.lenet_ready = 1'b1;
            eng.lenet_digit = 4'd0;
            eng_busy = 1'b0;
        end else if (eng_busy) begin
            eng_cnt++;
            if (eng_cnt == 1) eng.lenet_ready = 1'b0;
            if (!eng_hang && eng_cnt >= eng_len + 1) begin
                eng.lenet_ready = 1'b1;
                eng.lenet_digit = eng_digit;
                eng_busy = 1'b0;
            end
        end else if (eng.lenet_go === 1'b1) begin
            eng_busy = 1'b1;
            eng_cnt = 0;
        end
        if (eng.lenet_go === 1'b1) go_count++;
        if (frame_lock === 1'b1) fl_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        data_ready = 1'b1;
        tick(4);
        data_ready = 1'b0;
    endtask

    // Pulse with launch-latency checks: go low through cycle 3, high in cycle 4, low again in cycle 5.
    task automatic pulse_launch(input string tag);
        data_ready = 1'b1;
        tick(3);
        chk({tag, "_go_early"}, 32'(eng.lenet_go), 32'd0);
        tick(1);
        chk({tag, "_go_cycle4"}, 32'(eng.lenet_go), 32'd1);
        data_ready = 1'b0;
        tick(1);
        chk({tag, "_go_single"}, 32'(eng.lenet_go), 32'd0);
    endtask

    task automatic run_frame(input logic [3:0] d);
        eng_digit = d;
        pulse();
        tick(eng_len + 10);
    endtask

    initial begin
        tick(3);
        chk("rst_go", 32'(eng.lenet_go), 32'd0);
        chk("rst_lock", 32'(frame_lock), 32'd0);
        chk("rst_digit", 32'(digit_out), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_runs", 32'(run_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick(3);

        // Single frame, 100-cycle run: lock spans LAUNCH..CAPTURE = 103 cycles.
        eng_digit = 4'd7;
        fl_cnt = 0;
        pulse_launch("single");
        tick(110);
        chk("single_gos", 32'(go_count), 32'd1);
        chk("single_lock_len", 32'(fl_cnt), 32'd103);
        chk("single_runs", 32'(run_count), 32'd1);
        chk("single_valid", 32'(digit_valid), 32'd0);

        // Pause: pending held while disabled, launch on the cycle after enable rises.
        eng_len = 20;
        enable = 1'b0;
        eng_digit = 4'd12;
        pulse();
        tick(20);
        chk("pause_no_go", 32'(go_count), 32'd1);
        enable = 1'b1;
        tick(1);
        chk("pause_go", 32'(eng.lenet_go), 32'd1);
        tick(eng_len + 10);
        chk("pause_runs", 32'(run_count), 32'd2);
        chk("pause_digit", 32'(digit_out), 32'd0);
        chk("pause_valid", 32'(digit_valid), 32'd0);

        // Stability: 7,7,7 publishes 7; a later 3 does not.
        run_frame(4'd7);
        run_frame(4'd7);
        chk("stab_valid_2", 32'(digit_valid), 32'd0);
        run_frame(4'd7);
        chk("stab_valid_3", 32'(digit_valid), 32'd1);
        chk("stab_digit_3", 32'(digit_out), 32'd7);
        chk("stab_runs", 32'(run_count), 32'd5);
        run_frame(4'd3);
        chk("stab_hold_3", 32'(digit_out), 32'd7);

        // 4,4,12,4: the out-of-range digit breaks the streak, so 4 is not published yet.
        run_frame(4'd4);
        run_frame(4'd4);
        run_frame(4'd12);
        run_frame(4'd4);
        chk("bad_digit_hold", 32'(digit_out), 32'd7);
        run_frame(4'd4);
        run_frame(4'd4);
        chk("streak_after_bad", 32'(digit_out), 32'd4);
        chk("streak_runs", 32'(run_count), 32'd12);

        // Back-pressure: one frame queued behind a run launches right after it.
        eng_len = 40;
        go_base = go_count;
        pulse();
        tick(10);
        pulse();
        tick(100);
        chk("bp2_gos", 32'(go_count - go_base), 32'd2);
        chk("bp2_overrun", 32'(overrun), 32'd0);
        chk("bp2_runs", 32'(run_count), 32'd14);

        eng_len = 60;
        go_base = go_count;
        pulse();
        tick(6);
        pulse();
        tick(6);
        pulse();
        tick(200);
        chk("bp3_gos", 32'(go_count - go_base), 32'd2);
        chk("bp3_overrun", 32'(overrun), 32'd1);
        chk("bp3_runs", 32'(run_count), 32'd16);

`ifdef LENET_WDOG_EN
        eng_len = 20;
        eng_hang = 1'b1;
        rc_base = run_count;
        pulse();
        tick(60);
        chk("wdog_flag", 32'(timeout_err), 32'd1);
        chk("wdog_lock", 32'(frame_lock), 32'd0);
        chk("wdog_runs", 32'(run_count), 32'(rc_base));
        eng_hang = 1'b0;
        tick(5);
`else
        chk("no_wdog_flag", 32'(timeout_err), 32'd0);
`endif

        // Reset while the engine is mid-run.
        eng_len = 40;
        pulse();
        tick(10);
        chk("mid_lock", 32'(frame_lock), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_go", 32'(eng.lenet_go), 32'd0);
        chk("mid_rst_lock", 32'(frame_lock), 32'd0);
        chk("mid_rst_digit", 32'(digit_out), 32'd0);
        chk("mid_rst_valid", 32'(digit_valid), 32'd0);
        chk("mid_rst_runs", 32'(run_count), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        eng_digit = 4'd5;
        pulse_launch("post_rst");
        tick(eng_len + 10);
        chk("post_rst_runs", 32'(run_count), 32'd1);
        chk("post_rst_lock", 32'(frame_lock), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
